// File: rtl/pwm_deadtime_comparator.sv
// Carrier-comparison PWM with complementary gate outputs and dead band.
// Build option: define PWM_SHADOW_EN to latch mod_in at the carrier valley.
module pwm_deadtime_comparator #(
  parameter int WIDTH    = 16,
  parameter int DT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic signed [WIDTH-1:0]    tri_in,
  input  logic signed [WIDTH-1:0]    mod_in,
  input  logic        [DT_WIDTH-1:0] dead_time,
  output logic                       pwm_hi,
  output logic                       pwm_lo,
  output logic                       in_deadband
);

  localparam logic [2:0] S_OFF   = 3'd0;
  localparam logic [2:0] S_DT_HI = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_DT_LO = 3'd3;
  localparam logic [2:0] S_LO    = 3'd4;

  localparam logic [DT_WIDTH-1:0] DT_ZERO = '0;
  localparam logic [DT_WIDTH-1:0] DT_ONE  =
    {{(DT_WIDTH-1){1'b0}}, 1'b1};

  logic signed [WIDTH-1:0] mod_eff;
  logic                    demand_d, demand_q;
  logic [2:0]              state_d, state_q;
  logic [DT_WIDTH-1:0]     dt_cnt_d, dt_cnt_q;
  logic                    pwm_hi_d, pwm_hi_q;
  logic                    pwm_lo_d, pwm_lo_q;
  logic                    in_db_d, in_db_q;

`ifdef PWM_SHADOW_EN
  localparam logic signed [WIDTH-1:0] VALLEY =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] mod_shadow_d, mod_shadow_q;

  // Reload the shadow only at the carrier valley
  always_comb begin
    mod_shadow_d = mod_shadow_q;
    if (tri_in == VALLEY) begin
      mod_shadow_d = mod_in;
    end
  end

  // Shadow register
  always_ff @(posedge clk) begin
    if (reset) begin
      mod_shadow_q <= '0;
    end else begin
      mod_shadow_q <= mod_shadow_d;
    end
  end

  assign mod_eff = mod_shadow_q;
`else
  assign mod_eff = mod_in;
`endif

  // Strict signed carrier comparison; no arithmetic, so no overflow
  always_comb begin
    demand_d = (mod_eff > tri_in);
  end

  // Dead-band state machine; aborts are safe as the far gate never fired
  always_comb begin
    state_d  = state_q;
    dt_cnt_d = dt_cnt_q;
    if (!enable) begin
      state_d  = S_OFF;
      dt_cnt_d = DT_ZERO;
    end else begin
      unique case (state_q)
        S_OFF: begin
          state_d  = demand_q ? S_DT_HI : S_DT_LO;
          dt_cnt_d = dead_time;
        end
        S_HI: begin
          if (!demand_q) begin
            state_d  = S_DT_LO;
            dt_cnt_d = dead_time;
          end
        end
        S_LO: begin
          if (demand_q) begin
            state_d  = S_DT_HI;
            dt_cnt_d = dead_time;
          end
        end
        S_DT_HI: begin
          if (!demand_q) begin
            state_d = S_LO;
          end else if (dt_cnt_q == DT_ZERO) begin
            state_d = S_HI;
          end else begin
            dt_cnt_d = dt_cnt_q - DT_ONE;
          end
        end
        S_DT_LO: begin
          if (demand_q) begin
            state_d = S_HI;
          end else if (dt_cnt_q == DT_ZERO) begin
            state_d = S_LO;
          end else begin
            dt_cnt_d = dt_cnt_q - DT_ONE;
          end
        end
        default: begin
          state_d  = S_OFF;
          dt_cnt_d = DT_ZERO;
        end
      endcase
    end
  end

  // Gate drives decoded from the next state
  always_comb begin
    pwm_hi_d = (state_d == S_HI);
    pwm_lo_d = (state_d == S_LO);
    in_db_d  = (state_d == S_DT_HI) || (state_d == S_DT_LO);
  end

  // Pipeline and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      demand_q <= 1'b0;
      state_q  <= S_OFF;
      dt_cnt_q <= DT_ZERO;
      pwm_hi_q <= 1'b0;
      pwm_lo_q <= 1'b0;
      in_db_q  <= 1'b0;
    end else begin
      demand_q <= demand_d;
      state_q  <= state_d;
      dt_cnt_q <= dt_cnt_d;
      pwm_hi_q <= pwm_hi_d;
      pwm_lo_q <= pwm_lo_d;
      in_db_q  <= in_db_d;
    end
  end

  assign pwm_hi      = pwm_hi_q;
  assign pwm_lo      = pwm_lo_q;
  assign in_deadband = in_db_q;

endmodule

// File: tb/tb_pwm_deadtime_comparator.sv
// Directed-vector scoreboard bench for pwm_deadtime_comparator.
// Expected gate states are hand-derived per clock edge.
module tb_pwm_deadtime_comparator;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic signed [15:0] tri_in;
  logic signed [15:0] mod_in;
  logic [7:0]         dead_time;
  logic               pwm_hi;
  logic               pwm_lo;
  logic               in_deadband;

  typedef struct {
    logic               r;
    logic               en;
    logic signed [15:0] tv;
    logic signed [15:0] mv;
    logic [7:0]         dt;
    logic [2:0]         exp;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] sb[$];
  int         tags[$];
  int         checks = 0;
  int         failures = 0;
  bit         done = 1'b0;

  pwm_deadtime_comparator #(.WIDTH(16), .DT_WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .tri_in      (tri_in),
    .mod_in      (mod_in),
    .dead_time   (dead_time),
    .pwm_hi      (pwm_hi),
    .pwm_lo      (pwm_lo),
    .in_deadband (in_deadband)
  );

  always #5 clk = ~clk;

  // exp = {hi, lo, deadband} after the edge that samples these inputs
  task automatic add(input bit r, input bit en, input int tv,
                     input int mv, input int dt, input logic [2:0] e);
    vec_t v;
    v.r   = r;
    v.en  = en;
    v.tv  = 16'(tv);
    v.mv  = 16'(mv);
    v.dt  = 8'(dt);
    v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
`ifndef PWM_SHADOW_EN
    add(1, 1, -100, 0, 3, 3'b000);
    add(1, 1, -100, 0, 3, 3'b000);
    add(1, 1, -100, 0, 3, 3'b000);
    add(0, 0, -100, 0, 3, 3'b000);
    add(0, 1, -100, 0, 3, 3'b001);
    add(0, 1, -100, 0, 7, 3'b001);
    add(0, 1, -100, 0, 7, 3'b001);
    add(0, 1, -100, 0, 7, 3'b001);
    add(0, 1, -100, 0, 7, 3'b100);
    add(0, 1, -100, 0, 7, 3'b100);
    add(0, 1, 100, 0, 2, 3'b100);
    add(0, 1, 100, 0, 2, 3'b001);
    add(0, 1, 100, 0, 2, 3'b001);
    add(0, 1, 100, 0, 2, 3'b001);
    add(0, 1, 100, 0, 2, 3'b010);
    add(0, 1, 100, 0, 2, 3'b010);
    add(0, 1, -100, 0, 0, 3'b010);
    add(0, 1, -100, 0, 0, 3'b001);
    add(0, 1, -100, 0, 0, 3'b100);
    add(0, 1, 100, 0, 10, 3'b100);
    add(0, 1, 100, 0, 10, 3'b001);
    add(0, 1, -100, 0, 10, 3'b001);
    add(0, 1, -100, 0, 10, 3'b100);
    add(0, 1, -100, 0, 10, 3'b100);
    add(0, 1, -32768, -32768, 0, 3'b100);
    add(0, 1, 0, -32768, 0, 3'b001);
    add(0, 1, 32767, -32768, 0, 3'b010);
    add(0, 1, -32767, -32768, 0, 3'b010);
    add(0, 1, -32768, 32767, 0, 3'b010);
    add(0, 1, 32767, 32767, 0, 3'b001);
    add(0, 1, 0, 32767, 0, 3'b010);
    add(0, 1, 0, 32767, 0, 3'b001);
    add(0, 1, 0, 32767, 0, 3'b100);
    add(0, 1, 0, 32767, 0, 3'b100);
    add(0, 0, 0, 32767, 5, 3'b000);
    add(0, 1, 0, 32767, 5, 3'b001);
    add(0, 1, 0, 32767, 5, 3'b001);
    add(1, 1, 0, 32767, 5, 3'b000);
    add(0, 1, 0, 32767, 1, 3'b001);
    add(0, 1, 0, 32767, 1, 3'b100);
`else
    add(1, 1, -100, 0, 0, 3'b000);
    add(1, 1, -100, 0, 0, 3'b000);
    add(0, 0, -100, 500, 0, 3'b000);
    add(0, 1, -100, 500, 0, 3'b001);
    add(0, 1, 100, 500, 0, 3'b100);
    add(0, 1, 100, 500, 0, 3'b001);
    add(0, 1, -32768, 500, 0, 3'b010);
    add(0, 1, 100, 0, 0, 3'b001);
    add(0, 1, 100, 0, 0, 3'b100);
    add(0, 1, 100, 0, 0, 3'b100);
`endif
    reset     = 1'b1;
    enable    = 1'b0;
    tri_in    = '0;
    mod_in    = '0;
    dead_time = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      reset     = vecs[i].r;
      enable    = vecs[i].en;
      tri_in    = vecs[i].tv;
      mod_in    = vecs[i].mv;
      dead_time = vecs[i].dt;
      @(posedge clk);
      sb.push_back(vecs[i].exp);
      tags.push_back(i);
      #1;
    end
    @(negedge clk);
    @(negedge clk);
    done = 1'b1;
  end

  // Monitor: pop one expectation per presented output cycle
  initial begin
    logic [2:0] got;
    logic [2:0] want;
    int         tag;
    while (!done) begin
      @(negedge clk);
      if (pwm_hi && pwm_lo) begin
        failures++;
        $display("FAIL overlap t=%0t hi=%0b lo=%0b required not both 1",
                 $time, pwm_hi, pwm_lo);
      end
      if (sb.size() > 0) begin
        want = sb.pop_front();
        tag  = tags.pop_front();
        got  = {pwm_hi, pwm_lo, in_deadband};
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL vec%0d {hi,lo,db} got=%b required=%b",
                   tag, got, want);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached without summary");
    $fatal(1, "timeout");
  end

endmodule
